// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch/execute sequencer for a simple core.
//
// Sequence: IDLE -> FETCH (wait for imem_ready) -> EXEC -> FETCH ...
// A misaligned next PC parks the FSM in ERR until reset.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   PCSrc, imm_ext, stall  branch decision, branch offset, hold (EXEC only)
//   imem_ready, imem_rdata instruction memory response (FETCH only)
//   imem_req, imem_addr    fetch request and address (imem_addr == pc)
//   instr, instr_valid, pc instruction being executed and its address
//   misalign_err           sticky misaligned-target flag
//   taken_count            taken-branch counter, saturating
//
// Optional feature: define BRANCH_STATS_EN to add the taken_count port and
// its counter. The default build has neither.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCSrc,
    input  logic [31:0] imm_ext,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        misalign_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] taken_count
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    // Modulo-2^32 adder; wrap-around is legal and never flags an error.
    assign next_pc = PCSrc ? (pc + imm_ext) : (pc + 32'd4);

    // Outputs decode the registered state, so an asynchronous reset drops
    // imem_req and instr_valid immediately.
    assign imem_req     = (state == FETCH);
    assign imem_addr    = pc;
    assign instr_valid  = (state == EXEC);
    assign misalign_err = (state == ERR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= RESET_VECTOR;
            instr <= NOP;
`ifdef BRANCH_STATS_EN
            taken_count <= 32'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc <= next_pc;
                        if (next_pc[1:0] != 2'b00) begin
                            state <= ERR;
                        end else begin
                            state <= FETCH;
                        end
`ifdef BRANCH_STATS_EN
                        // Counts every taken branch, including one into ERR.
                        if (PCSrc && (taken_count != 32'hFFFF_FFFF)) begin
                            taken_count <= taken_count + 32'd1;
                        end
`endif
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scoreboard bench for pc_fetch_ctrl.
// Stimulus pushes expected EXEC/ERR entries; a monitor pops on each new one.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        PCSrc;
    logic [31:0] imm_ext;
    logic        stall;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        misalign_err;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count;
`endif

    pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .PCSrc        (PCSrc),
        .imm_ext      (imm_ext),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .misalign_err (misalign_err)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count  (taken_count)
`endif
    );

    typedef struct {
        bit          err;
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Memory image: each word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exec(input logic [31:0] p);
        exp_t e;
        e.err = 1'b0;
        e.pc  = p;
        e.ins = mem_word(p);
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [31:0] p);
        exp_t e;
        e.err = 1'b1;
        e.pc  = p;
        e.ins = 32'h0;
        exp_q.push_back(e);
    endtask

    // Monitor: a new EXEC (instr_valid rising) or a new ERR (misalign_err
    // rising) consumes one scoreboard entry.
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if ((instr_valid && !prev_valid) || (misalign_err && !prev_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got pc %h valid %b err %b expected none",
                         pc, instr_valid, misalign_err);
            end else begin
                e = exp_q.pop_front();
                chk("mon_kind", {31'd0, misalign_err}, {31'd0, e.err});
                chk("mon_pc", pc, e.pc);
                if (!e.err) begin
                    chk("mon_instr", instr, e.ins);
                end
            end
        end
        prev_valid = instr_valid;
        prev_err   = misalign_err;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        PCSrc      = 1'b0;
        imm_ext    = 32'h0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        repeat (2) tick();

        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rst_cnt", taken_count, 32'd0);
`endif

        // Sequential run: fetch and execute alternate.
        push_exec(32'h0);
        push_exec(32'h4);
        push_exec(32'h8);
        push_exec(32'hC);
        push_exec(32'h10);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("seq_req", {31'd0, imem_req}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("seq_valid", {31'd0, instr_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                chk("seq_addr", imem_addr, 32'(4 * (k / 2)));
            end
        end
        repeat (4) tick();

        // Backward branch from 0x10 by -8.
        push_exec(32'h8);
        PCSrc   = 1'b1;
        imm_ext = 32'hFFFF_FFF8;
        tick();
        PCSrc   = 1'b0;
        imm_ext = 32'h0;
        chk("br_addr", imem_addr, 32'h8);
`ifdef BRANCH_STATS_EN
        chk("br_cnt", taken_count, 32'd1);
`endif

        // Memory wait states: request held with stable address.
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_instr", instr, 32'hA000_0010);
            if (i < 3) tick();
        end
        imem_ready = 1'b1;
        tick();

        // Stall with a pending taken branch.
        stall   = 1'b1;
        PCSrc   = 1'b1;
        imm_ext = 32'h10;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_pc", pc, 32'h8);
            chk("stall_instr", instr, 32'hA000_0008);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
`ifdef BRANCH_STATS_EN
            chk("stall_cnt", taken_count, 32'd1);
`endif
        end
        push_exec(32'h18);
        push_exec(32'h1C);
        push_exec(32'h20);
        stall = 1'b0;
        tick();
        PCSrc   = 1'b0;
        imm_ext = 32'h0;
        chk("stall_br_addr", imem_addr, 32'h18);
`ifdef BRANCH_STATS_EN
        chk("stall_br_cnt", taken_count, 32'd2);
`endif
        repeat (5) tick();

        // Misaligned target from 0x20 by +6.
        push_err(32'h26);
        PCSrc   = 1'b1;
        imm_ext = 32'h6;
        tick();
        PCSrc   = 1'b0;
        imm_ext = 32'h0;
        chk("err_pc", pc, 32'h26);
        chk("err_flag", {31'd0, misalign_err}, 32'd1);
        chk("err_req", {31'd0, imem_req}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("err_cnt", taken_count, 32'd3);
`endif
        repeat (2) tick();
        chk("err_hold_pc", pc, 32'h26);
        chk("err_hold_flag", {31'd0, misalign_err}, 32'd1);
        chk("err_hold_valid", {31'd0, instr_valid}, 32'd0);

        reset_n = 1'b0;
        #1;
        chk("err_rst_pc", pc, 32'h0);
        chk("err_rst_flag", {31'd0, misalign_err}, 32'd0);
        tick();
        push_exec(32'h0);
        reset_n = 1'b1;
        tick();
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        repeat (2) tick();

        // Reset mid-fetch with memory ready: nothing may reach EXEC.
        chk("mf_pre_req", {31'd0, imem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mf_req", {31'd0, imem_req}, 32'd0);
        chk("mf_instr", instr, 32'h0000_0013);
        chk("mf_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("mf_valid2", {31'd0, instr_valid}, 32'd0);

        // Wrap-around: 0xFFFF_FFFC + 4 -> 0 without error.
        push_exec(32'h0);
        push_exec(32'hFFFF_FFFC);
        push_exec(32'h0);
        reset_n = 1'b1;
        repeat (2) tick();
        PCSrc   = 1'b1;
        imm_ext = 32'hFFFF_FFFC;
        tick();
        PCSrc   = 1'b0;
        imm_ext = 32'h0;
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        repeat (2) tick();
        chk("wrap_addr0", imem_addr, 32'h0);
        chk("wrap_err", {31'd0, misalign_err}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("wrap_cnt", taken_count, 32'd1);
`endif
        repeat (3) tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 PCSrc  input  1  branch-taken decision (branch & zero) for the instruction in EXEC.
REQ-005 imm_ext  input  32  sign-extended branch byte offset for the instruction in EXEC.
REQ-006 stall  input  1  hold current instruction and PC while in EXEC.
REQ-007 imem_ready  input  1  instruction memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word from memory.
REQ-009 imem_req  output  1  fetch request, combinational from state.
REQ-010 imem_addr  output  32  fetch address, equal to pc.
REQ-011 instr  output  32  registered instruction word.
REQ-012 instr_valid  output  1  instr and pc are valid for execute.
REQ-013 pc  output  32  address of current instruction.
REQ-014 misalign_err  output  1  sticky misaligned-target error.
REQ-015 taken_count  output  32  taken-branch count (present only when BRANCH_STATS_EN is defined).

Function
REQ-016 FSM states SHALL be IDLE, FETCH, EXEC, ERR, held in a registered state variable.
REQ-017 IDLE: entered on reset; outputs idle; unconditional transition to FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc; stays in FETCH while imem_ready=0.
REQ-019 FETCH with imem_ready=1: instr<=imem_rdata, state->EXEC; instr_valid=1 from the next cycle.
REQ-020 EXEC: imem_req=0, instr_valid=1; stall=1 holds state, pc, instr unchanged.
REQ-021 EXEC with stall=0: next = PCSrc ? pc+imm_ext : pc+4; pc<=next.
REQ-022 EXEC with stall=0: if next[1:0]!=2'b00, state->ERR; otherwise state->FETCH.
REQ-023 ERR: misalign_err=1, imem_req=0, instr_valid=0, pc holds faulting target; exit only by reset.
REQ-024 Adder arithmetic SHALL be 32-bit modulo 2^32; wrap-around from 32'hFFFF_FFFC+4 gives 32'h0000_0000 with no error.
REQ-025 PCSrc, imm_ext, stall SHALL be ignored outside EXEC; imem_ready, imem_rdata ignored outside FETCH.
REQ-026 Minimum throughput: one instruction per 2 cycles (FETCH with imem_ready=1, then EXEC with stall=0).

Reset
REQ-027 reset_n=0 SHALL asynchronously force state=IDLE, pc=RESET_VECTOR, instr=32'h0000_0013 (NOP), instr_valid=0, misalign_err=0, imem_req=0, taken_count=0.
REQ-028 Reset asserted mid-FETCH or mid-EXEC SHALL drop imem_req and instr_valid in the same cycle and discard any pending instruction.
REQ-029 After reset_n deasserts, the first imem_req SHALL occur on the second rising edge (IDLE then FETCH).

Configuration
REQ-030 Macro BRANCH_STATS_EN defined: taken_count port and register exist; taken_count increments by 1 in every EXEC cycle with stall=0 and PCSrc=1 (including a branch that leads to ERR); it saturates at 32'hFFFF_FFFF.
REQ-031 Macro BRANCH_STATS_EN undefined: no taken_count port and no counter logic; all other behaviour is identical.

Verification
REQ-032 Reset release, imem_ready tied 1, PCSrc=0, stall=0 -> imem_addr sequence 0x0,0x4,0x8 on every second cycle; instr_valid alternates 0/1.
REQ-033 In EXEC at pc=0x10, PCSrc=1, imm_ext=0xFFFF_FFF8 -> next imem_addr=0x08; taken_count increments by 1 when BRANCH_STATS_EN is defined.
REQ-034 imem_ready held 0 for 3 cycles in FETCH -> imem_req stays 1 with a stable address for 4 cycles; instr captured only on the ready cycle.
REQ-035 stall=1 for 2 cycles in EXEC with PCSrc=1 -> pc and instr unchanged, no counting; branch taken on the first cycle with stall=0.
REQ-036 In EXEC at pc=0x20, PCSrc=1, imm_ext=0x6 -> pc=0x26, misalign_err=1, imem_req stays 0; reset_n pulse -> pc=RESET_VECTOR, misalign_err=0.
REQ-037 reset_n asserted mid-FETCH with imem_ready=1 -> imem_req=0 and instr=0x0000_0013 immediately, with no instr_valid pulse.
